// File: rtl/div_sched_ctrl.sv
// Purpose: configures and sequences a clock-divider tick path (burst or continuous).
// Latency: first tick is registered period+1 edges after the start edge; ticks every period+1 cycles.
// Backpressure: cfg_ready drops while a shadowed period is pending in RUN and recovers on the next tick or stop.
module div_sched_ctrl #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 16,
  parameter logic [WIDTH-1:0] DEF_PERIOD = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [WIDTH-1:0] cfg_period,
  input  logic [CNT_W-1:0] cfg_count,
  input  logic             start,
  input  logic             stop,
  output logic             busy,
  output logic             tick,
  output logic             done,
  output logic [CNT_W-1:0] ticks_left
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  localparam logic [WIDTH-1:0] CTR_ONE = WIDTH'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] counter_q, counter_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] sh_period_q, sh_period_d;
  logic [CNT_W-1:0] sh_count_q, sh_count_d;
  logic             pending_q, pending_d;
  logic             tick_q, tick_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] ticks_left_q, ticks_left_d;
  logic             cfg_xfer;

  // Outside RUN config lands directly; in RUN only one shadowed write may be outstanding.
  assign cfg_ready  = (state_q != RUN) || !pending_q;
  assign cfg_xfer   = cfg_valid && cfg_ready;
  assign busy       = (state_q == RUN);
  assign tick       = tick_q;
  assign done       = done_q;
  assign ticks_left = ticks_left_q;

  // Next-state and datapath: run control, divide counter, shadow handling.
  always_comb begin
    state_d      = state_q;
    counter_d    = counter_q;
    period_d     = period_q;
    count_d      = count_q;
    sh_period_d  = sh_period_q;
    sh_count_d   = sh_count_q;
    pending_d    = pending_q;
    tick_d       = 1'b0;
    done_d       = done_q;
    ticks_left_d = ticks_left_q;
    case (state_q)
      IDLE, DONE: begin
        if (cfg_xfer) begin
          period_d = cfg_period;
          count_d  = cfg_count;
        end
        if (start) begin
          state_d      = RUN;
          counter_d    = '0;
          ticks_left_d = cfg_xfer ? cfg_count : count_q;
          done_d       = 1'b0;
        end
      end
      RUN: begin
        if (stop) begin
          // Abort wins over a coincident tick; any pending shadow is committed now.
          state_d      = IDLE;
          counter_d    = '0;
          ticks_left_d = '0;
          done_d       = 1'b0;
          pending_d    = 1'b0;
          if (pending_q) begin
            period_d = sh_period_q;
            count_d  = sh_count_q;
          end else if (cfg_xfer) begin
            period_d = cfg_period;
            count_d  = cfg_count;
          end
        end else begin
          if (cfg_xfer) begin
            sh_period_d = cfg_period;
            sh_count_d  = cfg_count;
            pending_d   = 1'b1;
          end
          if (counter_q == period_q) begin
            counter_d = '0;
            tick_d    = 1'b1;
            // Period swaps only at a tick boundary so no interval is ever shortened.
            if (pending_q) begin
              period_d  = sh_period_q;
              count_d   = sh_count_q;
              pending_d = 1'b0;
            end
            // A zero ticks_left means continuous mode; it never decrements.
            if (ticks_left_q != '0) begin
              ticks_left_d = ticks_left_q - CNT_ONE;
              if (ticks_left_q == CNT_ONE) begin
                state_d = DONE;
                done_d  = 1'b1;
              end
            end
          end else begin
            counter_d = counter_q + CTR_ONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset discards any shadowed configuration.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      counter_q    <= '0;
      period_q     <= DEF_PERIOD;
      count_q      <= '0;
      sh_period_q  <= '0;
      sh_count_q   <= '0;
      pending_q    <= 1'b0;
      tick_q       <= 1'b0;
      done_q       <= 1'b0;
      ticks_left_q <= '0;
    end else begin
      state_q      <= state_d;
      counter_q    <= counter_d;
      period_q     <= period_d;
      count_q      <= count_d;
      sh_period_q  <= sh_period_d;
      sh_count_q   <= sh_count_d;
      pending_q    <= pending_d;
      tick_q       <= tick_d;
      done_q       <= done_d;
      ticks_left_q <= ticks_left_d;
    end
  end

endmodule

// File: tb/tb_div_sched_ctrl.sv
// Purpose: self-checking bench for div_sched_ctrl with a tick-time scoreboard.
// Latency: observes outputs 1 time unit after each rising edge.
// Backpressure: drives cfg_valid against cfg_ready and checks acceptance.
module tb_div_sched_ctrl;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned CNT_W = 16;
  localparam logic [WIDTH-1:0] DEF_P = 32'd2;

  logic             clk;
  logic             rst;
  logic             cfg_valid;
  logic             cfg_ready;
  logic [WIDTH-1:0] cfg_period;
  logic [CNT_W-1:0] cfg_count;
  logic             start;
  logic             stop;
  logic             busy;
  logic             tick;
  logic             done;
  logic [CNT_W-1:0] ticks_left;

  int checks;
  int failures;
  int exp_q[$];

  div_sched_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W), .DEF_PERIOD(DEF_P)) dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_period(cfg_period), .cfg_count(cfg_count), .start(start), .stop(stop),
    .busy(busy), .tick(tick), .done(done), .ticks_left(ticks_left)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; cfg_valid = 1'b0; cfg_period = '0; cfg_count = '0; start = 1'b0; stop = 1'b0;
    #12;
    checks++;
    if ({busy, tick, done, cfg_ready} !== 4'b0001 || ticks_left !== '0) begin
      failures++;
      $display("FAIL reset_outputs: busy=%b tick=%b done=%b ready=%b left=%0d, want 0 0 0 1 0",
               busy, tick, done, cfg_ready, ticks_left);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_burst();
    int e, tl;
    cfg_valid = 1'b1; cfg_period = 32'd3; cfg_count = 16'd4;
    step();
    cfg_valid = 1'b0;
    checks++;
    if (cfg_ready !== 1'b1) begin failures++; $display("FAIL burst_cfg_ready: got %b want 1", cfg_ready); end
    start = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || ticks_left !== 16'd4) begin
      failures++; $display("FAIL burst_start: busy=%b left=%0d want 1 4", busy, ticks_left);
    end
    exp_q = {4, 8, 12, 16};
    for (int n = 1; n <= 18; n++) begin
      step();
      if (tick) begin
        checks++;
        if (exp_q.size() == 0) begin failures++; $display("FAIL burst_tick: unexpected tick at cycle %0d", n); end
        else begin
          e = exp_q.pop_front();
          if (e != n) begin failures++; $display("FAIL burst_tick: tick at cycle %0d want %0d", n, e); end
        end
      end
      tl = (n >= 16) ? 0 : 4 - n / 4;
      checks++;
      if (ticks_left !== CNT_W'(tl) || busy !== (n < 16) || done !== (n >= 16)) begin
        failures++;
        $display("FAIL burst_state c%0d: left=%0d busy=%b done=%b want %0d %b %b",
                 n, ticks_left, busy, done, tl, n < 16, n >= 16);
      end
    end
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL burst_missed: %0d ticks missing want 0", exp_q.size()); end
  endtask

  task automatic test_continuous_stop();
    int e;
    cfg_valid = 1'b1; cfg_period = '0; cfg_count = '0; start = 1'b1;
    step();
    cfg_valid = 1'b0; start = 1'b0;
    checks++;
    if (done !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL cont_start: done=%b busy=%b want 0 1", done, busy); end
    exp_q = {};
    for (int n = 1; n <= 10; n++) exp_q.push_back(n);
    for (int n = 1; n <= 10; n++) begin
      step();
      checks++;
      if (!tick || exp_q.size() == 0) begin failures++; $display("FAIL cont_tick: tick=%b at cycle %0d want 1", tick, n); end
      else begin
        e = exp_q.pop_front();
        if (e != n || ticks_left !== '0) begin
          failures++; $display("FAIL cont_tick: cycle %0d exp %0d left=%0d want 0", n, e, ticks_left);
        end
      end
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    checks++;
    if ({tick, busy, done} !== 3'b000) begin
      failures++; $display("FAIL cont_stop: tick=%b busy=%b done=%b want 0 0 0", tick, busy, done);
    end
    for (int n = 0; n < 3; n++) begin
      step();
      checks++;
      if (tick !== 1'b0) begin failures++; $display("FAIL cont_after_stop: tick=%b want 0", tick); end
    end
  endtask

  task automatic test_shadow();
    int e;
    cfg_valid = 1'b1; cfg_period = 32'd9; cfg_count = '0;
    step();
    cfg_valid = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    exp_q = {10, 13, 16, 19};
    for (int n = 1; n <= 20; n++) begin
      if (n == 5) begin cfg_valid = 1'b1; cfg_period = 32'd2; end
      if (n == 6) cfg_period = 32'd7;
      if (n == 11) cfg_valid = 1'b0;
      step();
      checks++;
      if (cfg_ready !== (n < 5 || n >= 10)) begin
        failures++; $display("FAIL shadow_ready c%0d: got %b want %b", n, cfg_ready, n < 5 || n >= 10);
      end
      if (tick) begin
        checks++;
        if (exp_q.size() == 0) begin failures++; $display("FAIL shadow_tick: unexpected tick at cycle %0d", n); end
        else begin
          e = exp_q.pop_front();
          if (e != n) begin failures++; $display("FAIL shadow_tick: tick at cycle %0d want %0d", n, e); end
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL shadow_missed: %0d ticks missing want 0", exp_q.size()); end
    stop = 1'b1;
    step();
    stop = 1'b0;
  endtask

  task automatic test_stop_on_tick();
    cfg_valid = 1'b1; cfg_period = 32'd4; cfg_count = 16'd2; start = 1'b1;
    step();
    cfg_valid = 1'b0; start = 1'b0;
    checks++;
    if (busy !== 1'b1 || ticks_left !== 16'd2) begin
      failures++; $display("FAIL stop_cfg_start: busy=%b left=%0d want 1 2", busy, ticks_left);
    end
    for (int n = 1; n <= 4; n++) begin
      step();
      checks++;
      if (tick !== 1'b0 || ticks_left !== 16'd2) begin
        failures++; $display("FAIL stop_pre c%0d: tick=%b left=%0d want 0 2", n, tick, ticks_left);
      end
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    checks++;
    if ({tick, busy, done} !== 3'b000 || ticks_left !== '0) begin
      failures++; $display("FAIL stop_on_tick: tick=%b busy=%b done=%b left=%0d want 0 0 0 0", tick, busy, done, ticks_left);
    end
    step();
    checks++;
    if (tick !== 1'b0) begin failures++; $display("FAIL stop_after: tick=%b want 0", tick); end
  endtask

  task automatic test_done_restart();
    int e;
    cfg_valid = 1'b1; cfg_period = '0; cfg_count = 16'd2;
    step();
    cfg_valid = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    checks++;
    if ({tick, done, busy} !== 3'b110) begin
      failures++; $display("FAIL done_reach: tick=%b done=%b busy=%b want 1 1 0", tick, done, busy);
    end
    cfg_valid = 1'b1; cfg_period = 32'd1; cfg_count = 16'd3;
    step();
    cfg_valid = 1'b0;
    checks++;
    if ({tick, done, cfg_ready} !== 3'b011) begin
      failures++; $display("FAIL done_cfg: tick=%b done=%b ready=%b want 0 1 1", tick, done, cfg_ready);
    end
    start = 1'b1; stop = 1'b1;
    step();
    start = 1'b0; stop = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0 || ticks_left !== 16'd3) begin
      failures++; $display("FAIL done_restart: busy=%b done=%b left=%0d want 1 0 3", busy, done, ticks_left);
    end
    exp_q = {2, 4, 6};
    for (int n = 1; n <= 8; n++) begin
      step();
      if (tick) begin
        checks++;
        if (exp_q.size() == 0) begin failures++; $display("FAIL restart_tick: unexpected tick at cycle %0d", n); end
        else begin
          e = exp_q.pop_front();
          if (e != n) begin failures++; $display("FAIL restart_tick: tick at cycle %0d want %0d", n, e); end
        end
      end
    end
    checks++;
    if (exp_q.size() != 0 || done !== 1'b1) begin
      failures++; $display("FAIL restart_end: missing=%0d done=%b want 0 1", exp_q.size(), done);
    end
  endtask

  task automatic test_reset_mid_run();
    int e;
    cfg_valid = 1'b1; cfg_period = 32'd5; cfg_count = 16'd3;
    step();
    cfg_valid = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    for (int n = 1; n <= 6; n++) step();
    checks++;
    if (tick !== 1'b1 || ticks_left !== 16'd2) begin
      failures++; $display("FAIL rstrun_first: tick=%b left=%0d want 1 2", tick, ticks_left);
    end
    cfg_valid = 1'b1; cfg_period = 32'd7; cfg_count = 16'd9;
    step();
    cfg_valid = 1'b0;
    checks++;
    if (cfg_ready !== 1'b0) begin failures++; $display("FAIL rstrun_pending: ready=%b want 0", cfg_ready); end
    rst = 1'b0;
    #1;
    checks++;
    if ({busy, tick, done, cfg_ready} !== 4'b0001 || ticks_left !== '0) begin
      failures++; $display("FAIL rstrun_async: busy=%b tick=%b done=%b ready=%b left=%0d want 0 0 0 1 0",
                           busy, tick, done, cfg_ready, ticks_left);
    end
    #3;
    rst = 1'b1;
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || ticks_left !== '0) begin
      failures++; $display("FAIL rstrun_restart: busy=%b left=%0d want 1 0", busy, ticks_left);
    end
    exp_q = {3, 6, 9};
    for (int n = 1; n <= 10; n++) begin
      step();
      if (tick) begin
        checks++;
        if (exp_q.size() == 0) begin failures++; $display("FAIL rstrun_tick: unexpected tick at cycle %0d", n); end
        else begin
          e = exp_q.pop_front();
          if (e != n) begin failures++; $display("FAIL rstrun_tick: tick at cycle %0d want %0d", n, e); end
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL rstrun_missed: %0d ticks missing want 0", exp_q.size()); end
    stop = 1'b1;
    step();
    stop = 1'b0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_burst();
    test_continuous_stop();
    test_shadow();
    test_stop_on_tick();
    test_done_restart();
    test_reset_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
